// File: rtl/wimax_burst_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// Package_wimax
//   Shared definitions for the WiMAX PHY transmit front end.
//   - burst_state_t        : burst sequencer state encoding
//   - WIMAX_BLOCK_BITS     : bits per randomizer/FEC block
//   - WIMAX_SYMS_PER_BLOCK : QPSK rate-1/2 modulator symbols per block
// ----------------------------------------------------------------------------
package Package_wimax;

    localparam int WIMAX_BLOCK_BITS     = 96;
    localparam int WIMAX_SYMS_PER_BLOCK = 96;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        STREAM,
        GAP,
        DRAIN,
        DONE
    } burst_state_t;

endpackage

// File: rtl/wimax_burst_ctrl.sv
// ----------------------------------------------------------------------------
// wimax_burst_ctrl
//   Burst sequencer in front of the PHY transmit chain. Accepts a request for
//   N blocks, pulses the PRBS seed load, serializes each block MSB-first into
//   the randomizer under ready/valid and inserts an idle gap between blocks.
//
//   Optional feature macro: WIMAX_BURST_DRAIN_EN
//     defined   -> burst held open (DRAIN) until num_blocks*SYMS_PER_BLOCK
//                  sym_tick pulses have been counted since LOAD
//     undefined -> DONE follows the last streamed bit, sym_tick unused
//
//   Ports
//     clk_50, reset          : clock, synchronous active-high reset
//     start, num_blocks      : burst request and length (clamped to MAX_BLOCKS)
//     abort                  : cancel the active burst
//     blk_data/valid/ready   : block source handshake
//     prbs_load, prbs_en     : randomizer seed load / enable
//     prbs_data_in/valid_in  : serial bit stream, prbs_ready_out back-pressure
//     sym_tick               : one pulse per modulator symbol
//     busy, done, aborted    : status; done/aborted are one-cycle pulses
//     blk_count              : blocks fully sent in current/last burst
//   All outputs are registered.
// ----------------------------------------------------------------------------
module wimax_burst_ctrl
    import Package_wimax::*;
#(
    parameter int BLOCK_BITS     = WIMAX_BLOCK_BITS,
    parameter int MAX_BLOCKS     = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int SYMS_PER_BLOCK = WIMAX_SYMS_PER_BLOCK
) (
    input  logic                              clk_50,
    input  logic                              reset,
    input  logic                              start,
    input  logic [$clog2(MAX_BLOCKS+1)-1:0]   num_blocks,
    input  logic                              abort,
    input  logic [BLOCK_BITS-1:0]             blk_data,
    input  logic                              blk_valid,
    output logic                              blk_ready,
    output logic                              prbs_load,
    output logic                              prbs_en,
    output logic                              prbs_data_in,
    output logic                              prbs_valid_in,
    input  logic                              prbs_ready_out,
    input  logic                              sym_tick,
    output logic                              busy,
    output logic                              done,
    output logic                              aborted,
    output logic [$clog2(MAX_BLOCKS+1)-1:0]   blk_count
);

    localparam int CNT_W = $clog2(MAX_BLOCKS + 1);
    localparam int BIT_W = $clog2(BLOCK_BITS);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    burst_state_t            state, state_nxt;
    logic [BLOCK_BITS-1:0]   shreg;
    logic [BIT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        num_lat;
    logic [CNT_W-1:0]        num_clamp;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    start_ok;
    logic                    start_zero;
    logic                    blk_take;
    logic                    bit_take;
    logic                    last_blk;

`ifdef WIMAX_BURST_DRAIN_EN
    localparam int SYM_W = $clog2(MAX_BLOCKS * SYMS_PER_BLOCK + 1);
    logic [SYM_W-1:0] sym_cnt, sym_cnt_nxt, sym_target;
    logic             sym_inc;

    // Counts from LOAD through DRAIN; saturates so it can never wrap.
    assign sym_inc     = sym_tick && !(state inside {IDLE, DONE}) && (sym_cnt != '1);
    assign sym_cnt_nxt = sym_cnt + SYM_W'(sym_inc);
    assign sym_target  = SYM_W'(num_lat) * SYM_W'(SYMS_PER_BLOCK);
`else
    logic unused_sym_tick;
    assign unused_sym_tick = sym_tick;
`endif

    assign num_clamp  = (num_blocks > CNT_W'(MAX_BLOCKS)) ? CNT_W'(MAX_BLOCKS) : num_blocks;
    assign start_ok   = (state == IDLE) && start && (num_blocks != '0);
    assign start_zero = (state == IDLE) && start && (num_blocks == '0);
    assign blk_take   = (state == FETCH) && blk_valid && blk_ready;
    assign bit_take   = (state == STREAM) && prbs_ready_out;
    assign last_blk   = (blk_count + CNT_W'(1)) == num_lat;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start_ok) state_nxt = LOAD;
            LOAD:   state_nxt = FETCH;
            FETCH:  if (blk_take) state_nxt = STREAM;
            STREAM: begin
                if (bit_take && (bit_cnt == '0)) begin
                    if (last_blk) begin
`ifdef WIMAX_BURST_DRAIN_EN
                        state_nxt = DRAIN;
`else
                        state_nxt = DONE;
`endif
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP:    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = FETCH;
`ifdef WIMAX_BURST_DRAIN_EN
            DRAIN:  if (sym_cnt_nxt >= sym_target) state_nxt = DONE;
`else
            DRAIN:  state_nxt = IDLE;
`endif
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort outranks every other transition, completion included
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    // Moore outputs are registered from the next state so they line up with
    // the state they describe without any input-to-output combinational path.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            num_lat       <= '0;
            gap_cnt       <= '0;
            blk_count     <= '0;
            blk_ready     <= 1'b0;
            prbs_load     <= 1'b0;
            prbs_en       <= 1'b0;
            prbs_data_in  <= 1'b0;
            prbs_valid_in <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
`ifdef WIMAX_BURST_DRAIN_EN
            sym_cnt       <= '0;
`endif
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != IDLE);
            prbs_load     <= (state_nxt == LOAD);
            blk_ready     <= (state_nxt == FETCH);
            prbs_en       <= state_nxt inside {LOAD, FETCH, STREAM, GAP, DRAIN};
            prbs_valid_in <= (state_nxt == STREAM);
            done          <= (state_nxt == DONE) || start_zero;
            aborted       <= abort && (state != IDLE);
`ifdef WIMAX_BURST_DRAIN_EN
            sym_cnt       <= start_ok ? '0 : sym_cnt_nxt;
`endif

            if (start_ok) begin
                num_lat   <= num_clamp;
                blk_count <= '0;
            end

            if (blk_take) begin
                shreg        <= blk_data;
                bit_cnt      <= BIT_W'(BLOCK_BITS - 1);
                prbs_data_in <= blk_data[BLOCK_BITS-1];
            end

            if (bit_take) begin
                if (bit_cnt == '0) begin
                    blk_count <= blk_count + CNT_W'(1);
                    gap_cnt   <= '0;
                end else begin
                    bit_cnt      <= bit_cnt - BIT_W'(1);
                    prbs_data_in <= shreg[bit_cnt - BIT_W'(1)];
                end
            end

            if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);

            // Data line parks low whenever nothing is being offered.
            if (state_nxt != STREAM) prbs_data_in <= 1'b0;
        end
    end

endmodule

// File: doc/wimax_burst_ctrl.md
# wimax_burst_ctrl

Burst sequencer sitting in front of the WiMAX PHY transmit chain (PRBS randomizer → FEC encoder → interleaver → QPSK modulator). It accepts a burst request of N 96-bit data blocks, pulses the PRBS seed load, serializes each block MSB-first into the randomizer under its ready/valid handshake, and inserts a programmable idle gap between blocks. Optionally, it holds the burst open until the modulator has emitted every expected symbol. It replaces the free-running block streamer used for bring-up and is the single point that drives the PHY's `data_in`, `valid_in`, `load` and `en` inputs.

## Interface
Parameters:
- `BLOCK_BITS`, 96: bits per randomizer/FEC block.
- `MAX_BLOCKS`, 16: largest burst length. `num_blocks` width is `$clog2(MAX_BLOCKS+1)`.
- `GAP_CYCLES`, 4: idle cycles between blocks. 0 is legal.
- `SYMS_PER_BLOCK`, 96: modulator symbols per block (QPSK, rate-1/2).

Ports:
- `clk_50`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle burst request. Ignored unless the block is in IDLE.
- `num_blocks`, in, 5: burst length. Sampled on an accepted `start`.
- `abort`, in, 1: cancels the burst.
- `blk_data`, in, 96: next block from the source.
- `blk_valid`, in, 1: `blk_data` is valid.
- `blk_ready`, out, 1: the controller accepts `blk_data` this cycle.
- `prbs_load`, out, 1: one-cycle seed load to the randomizer.
- `prbs_en`, out, 1: randomizer enable.
- `prbs_data_in`, out, 1: serial data to the randomizer.
- `prbs_valid_in`, out, 1: `prbs_data_in` is valid.
- `prbs_ready_out`, in, 1: randomizer accepts a bit.
- `sym_tick`, in, 1: one pulse per modulator output symbol, already synchronized to `clk_50`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse on normal burst completion.
- `aborted`, out, 1: one-cycle pulse on abort.
- `blk_count`, out, 5: number of blocks fully sent in the current or last burst.

## Operation
- State machine states: IDLE, LOAD, FETCH, STREAM, GAP, DRAIN, DONE.
- **IDLE**
  - `start` with `num_blocks != 0`: latch `num_blocks`, clear `blk_count`, go to LOAD.
  - `start` with `num_blocks == 0`: pulse `done` on the next cycle and stay in IDLE. No load is issued.
  - `num_blocks > MAX_BLOCKS` is clamped to `MAX_BLOCKS`.
- **LOAD**: `prbs_load` = 1 for exactly one cycle, then go to FETCH.
- **FETCH**
  - `blk_ready` = 1.
  - On `blk_valid && blk_ready`: copy `blk_data` into the shift register, set `bit_cnt` = `BLOCK_BITS-1`, go to STREAM.
- **STREAM**
  - `prbs_valid_in` = 1 and `prbs_data_in` = `shreg[bit_cnt]`, MSB first.
  - On each `prbs_ready_out`, decrement `bit_cnt`.
  - When the handshake completes with `bit_cnt == 0`, increment `blk_count`. Then:
    - if `blk_count+1 == num_blocks`, go to DRAIN (macro defined) or DONE (macro undefined);
    - otherwise go to GAP, or directly to FETCH if `GAP_CYCLES == 0`.
  - While `prbs_ready_out` = 0, data and valid are held stable.
- **GAP**: `prbs_valid_in` = 0 for `GAP_CYCLES` cycles, then go to FETCH.
- **DRAIN** (macro only)
  - Count `sym_tick` pulses. Ticks are counted from LOAD onward, including ticks during STREAM.
  - Go to DONE once the count reaches `num_blocks*SYMS_PER_BLOCK`.
- **DONE**: `done` = 1 for one cycle, then go to IDLE.
- `prbs_en` = 1 in LOAD, FETCH, STREAM, GAP and DRAIN, and 0 in IDLE and DONE.
- **`abort`** in any state other than IDLE:
  - the next state is IDLE;
  - `aborted` pulses for one cycle;
  - `done` is not pulsed;
  - `blk_count` keeps the number of completed blocks.
  - `abort` has priority over every other transition, including completion in the same cycle.
- **`start`** while busy is dropped silently.

## Timing
- Every output comes from a flop (registered Moore outputs). Zero combinational paths from inputs to outputs.
- Reset values: all outputs are 0, state is IDLE, all counters are 0.
- `start` accepted at cycle t:
  - `prbs_load` is high at t+1;
  - `blk_ready` is high from t+2.
- A block accepted at cycle f puts its first bit on `prbs_data_in` at f+1.
- A full block with `prbs_ready_out` held high takes exactly 96 STREAM cycles.
- Block-to-block gap with the source always valid is `GAP_CYCLES`+1 cycles: the GAP cycles plus one FETCH cycle.
- Minimum burst without DRAIN: 1 (LOAD) + N·(1+96) + (N−1)·`GAP_CYCLES` + 1 (DONE) cycles after `start`.
- `reset` asserted mid-burst takes effect at the next edge. `busy` = 0 on the following cycle, and no `done` or `aborted` pulse is produced.
- Symbol counter width is 11 bits (16·96 = 1536) and it never wraps.

## Configuration
- `WIMAX_BURST_DRAIN_EN`
  - **Defined**: the DRAIN state and symbol counter exist. `done` fires only after all expected symbols have been counted.
  - **Undefined**: STREAM goes directly to DONE after the last bit. `sym_tick` is unused and the counter is not instantiated.

## Structure
- In `Package_wimax`:
  - the state enum `burst_state_t`;
  - constants `WIMAX_BLOCK_BITS` = 96 and `WIMAX_SYMS_PER_BLOCK` = 96, used as parameter defaults.
- A single module with no sub-modules. The shift register and counters are inline.

## Test plan
- `num_blocks`=1, source always valid, `prbs_ready_out`=1:
  - one `prbs_load` pulse;
  - exactly 96 valid bits, MSB of `blk_data` first;
  - `done` at cycle 99 after `start` (macro undefined).
- `num_blocks`=3, `GAP_CYCLES`=4:
  - 288 valid bits;
  - valid low for exactly 5 cycles between blocks;
  - `blk_count`=3 at `done`.
- Randomly toggle `prbs_ready_out` (50% duty):
  - bit sequence unchanged;
  - data held while ready=0;
  - no bit dropped or duplicated.
- `num_blocks`=0 → `done` pulses the next cycle, with no `prbs_load` and no `blk_ready`.
- `abort` during the 40th bit of block 2 of 3:
  - `aborted` pulses;
  - `blk_count`=1;
  - valid=0 and `busy`=0 the next cycle;
  - no `done`.
- With `WIMAX_BURST_DRAIN_EN` defined and `num_blocks`=2, issue 191 `sym_tick` pulses → no `done`. The 192nd pulse → `done` on the next cycle.
